// File: rtl/cas_recorder.sv
// cas_recorder: decodes the console's cassette-write FSK into bytes and stores them in the CAS RAM.
// Latency: write strobe 2 clk_i cycles after the synchronized tap edge that completes bit 8.
// Backpressure: none; the RAM port takes one write per cycle, writes are dropped once full_o is set.
//
// Ports: clk_i / reset_n_i (async active-low), ce_i timebase enable, tap_i asynchronous FSK level,
//        motor_n_i / rec_en_i / rewind_i tape controls, ram_addr_o / ram_data_o / ram_we_o write
//        port, byte_cnt_o / busy_o / full_o / err_cnt_o status.
// Option: define CAS_RECORDER_HEADER_EN to write a 16 x 0x55 + 0x7F block header on every new leader.
module cas_recorder #(
    parameter int ADDR_W     = 18,
    parameter int MIN_HALF   = 300,
    parameter int SPLIT_HALF = 1677,
    parameter int GAP_HALF   = 8000,
    parameter int LEADER_MIN = 64
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              ce_i,
    input  logic              tap_i,
    input  logic              motor_n_i,
    input  logic              rec_en_i,
    input  logic              rewind_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_data_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] byte_cnt_o,
    output logic              busy_o,
    output logic              full_o,
    output logic [7:0]        err_cnt_o
);

    localparam int CNT_W  = 14;
    localparam int LEAD_W = $clog2(LEADER_MIN + 1);

    localparam logic [CNT_W-1:0]  MIN_C   = CNT_W'(MIN_HALF);
    localparam logic [CNT_W-1:0]  SPLIT_C = CNT_W'(SPLIT_HALF);
    localparam logic [CNT_W-1:0]  GAP_C   = CNT_W'(GAP_HALF);
    localparam logic [LEAD_W-1:0] LEAD_C  = LEAD_W'(LEADER_MIN);
    localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_START,
        ST_DATA,
        ST_STORE,
        ST_WAIT
    } state_t;

    // tap synchronizer; s3 is the previous synchronized level for edge detection
    logic tap_s1_q, tap_s1_d;
    logic tap_s2_q, tap_s2_d;
    logic tap_s3_q, tap_s3_d;

    logic [CNT_W-1:0]  period_q, period_d;
    state_t            state_q, state_d;
    logic [LEAD_W-1:0] lead_q, lead_d;
    logic [1:0]        half_q, half_d;       // halves pending in the current bit
    logic              pend_long_q, pend_long_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;         // write pointer, doubles as the stored-byte count
    logic              full_q, full_d;
    logic [7:0]        err_q, err_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_data_q, ram_data_d;
`ifdef CAS_RECORDER_HEADER_EN
    logic [4:0]        hdr_cnt_q, hdr_cnt_d; // header bytes still to write, 0 = idle
`endif

    logic       edge_det, glitch_evt, short_evt, long_evt, gap_evt;
    logic       run, hdr_busy;
    logic       bit_done, bit_val, data_err, frame_err;
    logic       wr_req;
    logic [7:0] wr_byte;

    always_comb begin
        tap_s1_d = tap_i;
        tap_s2_d = tap_s1_q;
        tap_s3_d = tap_s2_q;

        // Classify the half that just ended using the count before it is cleared.
        edge_det   = tap_s2_q ^ tap_s3_q;
        glitch_evt = edge_det && (period_q < MIN_C);
        short_evt  = edge_det && (period_q >= MIN_C) && (period_q < SPLIT_C);
        long_evt   = edge_det && (period_q >= SPLIT_C);
        // Fires only on the step into saturation, so a held level reports one gap.
        gap_evt    = !edge_det && ce_i && (period_q == GAP_C - 14'd1);

        period_d = period_q;
        if (edge_det) begin
            period_d = '0;
        end else if (ce_i && (period_q < GAP_C)) begin
            period_d = period_q + 1'b1;
        end

        run = !motor_n_i && rec_en_i;
`ifdef CAS_RECORDER_HEADER_EN
        hdr_busy = (hdr_cnt_q != 5'd0);
`else
        hdr_busy = 1'b0;
`endif

        state_d     = state_q;
        lead_d      = lead_q;
        half_d      = half_q;
        pend_long_d = pend_long_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        full_d      = full_q;
        err_d       = err_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
`ifdef CAS_RECORDER_HEADER_EN
        hdr_cnt_d   = hdr_cnt_q;
`endif
        bit_done    = 1'b0;
        bit_val     = 1'b0;
        data_err    = 1'b0;
        frame_err   = 1'b0;
        wr_req      = 1'b0;
        wr_byte     = shift_q;

        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_SYNC;
                    lead_d  = '0;
                end
            end

            ST_SYNC: begin
                if (short_evt) begin
                    if (lead_q != LEAD_C) lead_d = lead_q + 1'b1;
                end else if (long_evt) begin
                    // A long after a full leader is the first half of the start bit.
                    if (lead_q == LEAD_C) begin
                        state_d = ST_START;
`ifdef CAS_RECORDER_HEADER_EN
                        hdr_cnt_d = 5'd17;
`endif
                    end
                    lead_d = '0;
                end else if (glitch_evt || gap_evt) begin
                    lead_d = '0;
                end
            end

            ST_START: begin
                if (long_evt) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    half_d    = '0;
                end else if (short_evt || glitch_evt || gap_evt) begin
                    frame_err = 1'b1;
                    state_d   = ST_SYNC;
                    lead_d    = '0;
                end
            end

            ST_DATA: begin
                if (glitch_evt || gap_evt) begin
                    data_err = 1'b1;
                end else if (long_evt) begin
                    if (half_q == 2'd0) begin
                        half_d      = 2'd1;
                        pend_long_d = 1'b1;
                    end else if (pend_long_q) begin
                        bit_done = 1'b1;
                        bit_val  = 1'b0;
                    end else begin
                        data_err = 1'b1;
                    end
                end else if (short_evt) begin
                    if (half_q == 2'd0) begin
                        half_d      = 2'd1;
                        pend_long_d = 1'b0;
                    end else if (pend_long_q) begin
                        data_err = 1'b1;
                    end else if (half_q == 2'd3) begin
                        bit_done = 1'b1;
                        bit_val  = 1'b1;
                    end else begin
                        half_d = half_q + 1'b1;
                    end
                end

                if (bit_done) begin
                    shift_d   = {shift_q[6:0], bit_val};
                    half_d    = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = ST_STORE;
                end
                if (data_err) begin
                    frame_err = 1'b1;
                    state_d   = ST_SYNC;
                    lead_d    = '0;
                end
            end

            ST_STORE: begin
                // A still-streaming header keeps the write port; the byte waits its turn.
                if (!hdr_busy) begin
                    wr_req  = 1'b1;
                    wr_byte = shift_q;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (long_evt) begin
                    state_d = ST_START;
                end else if (gap_evt) begin
                    state_d = ST_SYNC;
                    lead_d  = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef CAS_RECORDER_HEADER_EN
        if (hdr_busy) begin
            wr_req    = 1'b1;
            wr_byte   = (hdr_cnt_q == 5'd1) ? 8'h7F : 8'h55;
            hdr_cnt_d = hdr_cnt_q - 1'b1;
        end
`endif

        // Pointer and count hold at the last address once full: an ADDR_W-bit
        // count cannot represent 2^ADDR_W, and wrapping would read as empty.
        if (wr_req && !full_q && run && !rewind_i) begin
            ram_we_d   = 1'b1;
            ram_addr_d = ptr_q;
            ram_data_d = wr_byte;
            if (ptr_q == PTR_MAX) begin
                full_d = 1'b1;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end

        if (frame_err && (err_q != 8'hFF)) err_d = err_q + 1'b1;

        if (rewind_i) begin
            ptr_d   = '0;
            full_d  = 1'b0;
            err_d   = '0;
            state_d = ST_SYNC;
            lead_d  = '0;
`ifdef CAS_RECORDER_HEADER_EN
            hdr_cnt_d = '0;
`endif
        end

        if (!run) begin
            state_d = ST_IDLE;
`ifdef CAS_RECORDER_HEADER_EN
            hdr_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tap_s1_q    <= 1'b0;
            tap_s2_q    <= 1'b0;
            tap_s3_q    <= 1'b0;
            period_q    <= '0;
            state_q     <= ST_IDLE;
            lead_q      <= '0;
            half_q      <= '0;
            pend_long_q <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            full_q      <= 1'b0;
            err_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
`ifdef CAS_RECORDER_HEADER_EN
            hdr_cnt_q   <= '0;
`endif
        end else begin
            tap_s1_q    <= tap_s1_d;
            tap_s2_q    <= tap_s2_d;
            tap_s3_q    <= tap_s3_d;
            period_q    <= period_d;
            state_q     <= state_d;
            lead_q      <= lead_d;
            half_q      <= half_d;
            pend_long_q <= pend_long_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            full_q      <= full_d;
            err_q       <= err_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
`ifdef CAS_RECORDER_HEADER_EN
            hdr_cnt_q   <= hdr_cnt_d;
`endif
        end
    end

    assign ram_addr_o = ram_addr_q;
    assign ram_data_o = ram_data_q;
    assign ram_we_o   = ram_we_q;
    assign byte_cnt_o = ptr_q;
    assign busy_o     = (state_q == ST_DATA);
    assign full_o     = full_q;
    assign err_cnt_o  = err_q;

endmodule
